vend_dispense_sequencer: RTL and testbench
==========================================

// Module: vend_dispense_sequencer
// PURPOSE
//  Sequences the physical dispense of one vend transaction: bottle motor, then nickel ejector, then dime ejector.
//  Sits between the coin-counting vending FSM (deliver/give_* outputs) and the mechanics; one actuator at a time.
//  Each actuator runs a min-hold / done-feedback / timeout handshake; a stalled mechanism latches a fault.
// PARAMETERS
//  PULSE_CYCLES   4     min cycles an actuator is held high before mech_done is honoured (>=2)
//  TIMEOUT_CYCLES 1000  max cycles in one actuator state before fault (> PULSE_CYCLES)
//  CNT_W          $clog2(TIMEOUT_CYCLES+1)  width of shared cycle counter (derived, not overridden)
// PORTS
//  clock          in   1  single clock, rising edge
//  reset          in   1  synchronous, ACTIVE-LOW (0 = reset)
//  req_valid      in   1  transaction request
//  req_deliver    in   1  dispense one bottle
//  req_nickel     in   1  return one nickel
//  req_dime       in   1  return one dime
//  req_doubledime in   1  return two dimes
//  req_ready      out  1  high only in IDLE; request accepted when req_valid & req_ready
//  mech_done      in   1  mechanism completion from the active actuator (level)
//  fault_clr      in   1  clears FAULT
//  motor_on       out  1  bottle motor drive
//  eject_nickel   out  1  nickel ejector drive
//  eject_dime     out  1  dime ejector drive
//  busy           out  1  high in every state except IDLE
//  done           out  1  one-cycle pulse on successful return to IDLE
//  fault          out  1  high while in FAULT
// BEHAVIOUR
//  Reset (reset==0 at clock edge): state=IDLE, all counters 0; every output 0 except req_ready=1. Reset mid-transaction
//   aborts immediately: actuators drop the cycle after the edge; the pending job is lost.
//  Accept (IDLE, req_valid=1): latch job: bottle=req_deliver, nick=req_nickel, dimes_left=req_dime+2*req_doubledime
//   (2-bit, 0..3). Next state SEL. req_* ignored outside IDLE.
//  SEL (1 cycle, all actuators 0): priority bottle > nick > dimes_left!=0 -> VEND / CHG_N / CHG_D; none left -> IDLE with done=1.
//   An empty request therefore gives done exactly 2 cycles after acceptance.
//  VEND/CHG_N/CHG_D: matching actuator is 1 for the whole state; cnt clears on entry, +1 per cycle, saturating.
//   Exit ok: mech_done==1 && cnt>=PULSE_CYCLES-1 -> clear that item (dimes_left-1 for CHG_D) -> SEL.
//   mech_done before the min hold is ignored (covers a stale done from the previous actuator).
//   Timeout: cnt==TIMEOUT_CYCLES-1 without ok exit -> FAULT. If ok and timeout coincide, ok wins.
//  FAULT: all actuators 0, fault=1, busy=1, req_ready=0; exit to IDLE only on fault_clr=1 (no done pulse). Job discarded.
//  At most one actuator is ever high; an actuator never goes low-to-high in the same cycle another goes high-to-low (SEL gap).
//  Outputs are Moore (decoded from registered state) except done, which is registered and goes high on the SEL->IDLE transition.
//  Latency, full job (bottle+nickel+2 dimes), mech_done immediate: 1 + 4*(PULSE_CYCLES+1) cycles accept-to-IDLE.
// STRUCTURE
//  vending_pkg: typedef enum logic [2:0] {IDLE, SEL, VEND, CHG_N, CHG_D, FAULT} disp_state_t;
//   coin value constants NICKEL_C=5, DIME_C=10, QUARTER_C=25, PRICE_C=25 (shared with the coin-counting FSM).
//  Sub-module vend_act_timer: counter with clear/enable, outputs min_ok (>=PULSE_CYCLES-1) and expired
//   (==TIMEOUT_CYCLES-1); one instance shared across actuator states. Next-state and output logic in
//   separate always blocks.
// TESTING (PULSE_CYCLES=4, TIMEOUT_CYCLES=20)
//  1 Reset: hold reset=0 3 cycles with req_valid=1 -> req_ready=1, all else 0, no acceptance; release -> accept.
//  2 deliver+nickel, mech_done tied 1 -> motor_on 4 cycles, 1 gap, eject_nickel 4 cycles, gap, done pulse; 11 cycles total.
//  3 doubledime only, done after 6 cycles each -> eject_dime two separate 6-cycle bursts with 1-cycle gap, dimes_left 2->1->0.
//  4 deliver, mech_done never asserted -> motor_on 20 cycles then FAULT, fault=1, req_ready=0; fault_clr -> IDLE, no done.
//  5 mech_done pulse at cycle 1 of VEND only -> ignored, motor_on stays high; done at cycle 7 -> exit honoured.
//  6 reset=0 mid CHG_N -> eject_nickel 0 next cycle, IDLE; empty request -> done exactly 2 cycles after accept.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and coin constants for the vending controller slice.
// The dispense sequencer uses the state type; the coin-counting FSM uses the coin values.
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    VEND,
    CHG_N,
    CHG_D,
    FAULT
  } disp_state_t;

  localparam int unsigned NICKEL_C  = 5;
  localparam int unsigned DIME_C    = 10;
  localparam int unsigned QUARTER_C = 25;
  localparam int unsigned PRICE_C   = 25;

endpackage

// File: rtl/vend_act_timer.sv
// Shared per-actuator cycle counter: reports when the minimum hold is met and when
// the current actuator has run out of time.
module vend_act_timer #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic min_ok,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXP_V = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    // NOTE: default first so every path assigns cnt_next and no latch is inferred.
    cnt_next = cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (en && (cnt != '1)) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  always_comb begin
    min_ok  = (cnt >= MIN_V);
    expired = (cnt == EXP_V);
  end

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Runs one vend job as bottle, then nickel, then dimes, one actuator at a time,
// with a one-cycle SEL gap between actuators and a latched fault on a stalled mechanism.
module vend_dispense_sequencer
  import vending_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic req_valid,
  input  logic req_deliver,
  input  logic req_nickel,
  input  logic req_dime,
  input  logic req_doubledime,
  output logic req_ready,
  input  logic mech_done,
  input  logic fault_clr,
  output logic motor_on,
  output logic eject_nickel,
  output logic eject_dime,
  output logic busy,
  output logic done,
  output logic fault
);

  disp_state_t state, state_next;
  logic        bottle, bottle_next;
  logic        nick, nick_next;
  logic [1:0]  dimes_left, dimes_next;
  logic        done_next;
  logic        active, min_ok, expired, exit_ok;

  assign active  = (state == VEND) || (state == CHG_N) || (state == CHG_D);
  // A mech_done arriving before the minimum hold is treated as stale and ignored.
  assign exit_ok = mech_done && min_ok;

  vend_act_timer #(
    .PULSE_CYCLES  (PULSE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clr    (!active),
    .en     (active),
    .min_ok (min_ok),
    .expired(expired)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      bottle     <= 1'b0;
      nick       <= 1'b0;
      dimes_left <= 2'd0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      bottle     <= bottle_next;
      nick       <= nick_next;
      dimes_left <= dimes_next;
      done       <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    bottle_next = bottle;
    nick_next   = nick;
    dimes_next  = dimes_left;
    done_next   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          bottle_next = req_deliver;
          nick_next   = req_nickel;
          dimes_next  = {1'b0, req_dime} + {req_doubledime, 1'b0};
          state_next  = SEL;
        end
      end
      SEL: begin
        if (bottle)                  state_next = VEND;
        else if (nick)               state_next = CHG_N;
        else if (dimes_left != 2'd0) state_next = CHG_D;
        else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      // Ok exit is checked before timeout so a coinciding completion still counts.
      VEND: begin
        if (exit_ok) begin
          bottle_next = 1'b0;
          state_next  = SEL;
        end else if (expired) begin
          state_next = FAULT;
        end
      end
      CHG_N: begin
        if (exit_ok) begin
          nick_next  = 1'b0;
          state_next = SEL;
        end else if (expired) begin
          state_next = FAULT;
        end
      end
      CHG_D: begin
        if (exit_ok) begin
          dimes_next = dimes_left - 2'd1;
          state_next = SEL;
        end else if (expired) begin
          state_next = FAULT;
        end
      end
      FAULT: begin
        bottle_next = 1'b0;
        nick_next   = 1'b0;
        dimes_next  = 2'd0;
        if (fault_clr) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state == IDLE);
    busy         = (state != IDLE);
    motor_on     = (state == VEND);
    eject_nickel = (state == CHG_N);
    eject_dime   = (state == CHG_D);
    fault        = (state == FAULT);
  end

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Directed bench for vend_dispense_sequencer: a cycle table for reset/accept/basic job,
// then hand sequences for dime bursts, timeout fault, stale done and mid-job reset.
module tb_vend_dispense_sequencer;

  logic clock;
  logic reset;
  logic req_valid, req_deliver, req_nickel, req_dime, req_doubledime;
  logic req_ready, mech_done, fault_clr;
  logic motor_on, eject_nickel, eject_dime, busy, done, fault;

  int n_vec = 0;
  int n_bad = 0;

  // Output word: {req_ready, busy, done, fault, motor_on, eject_nickel, eject_dime}
  localparam logic [6:0] O_IDLE = 7'b1000000;
  localparam logic [6:0] O_DONE = 7'b1010000;
  localparam logic [6:0] O_SEL  = 7'b0100000;
  localparam logic [6:0] O_FLT  = 7'b0101000;
  localparam logic [6:0] O_MOT  = 7'b0100100;
  localparam logic [6:0] O_NCK  = 7'b0100010;
  localparam logic [6:0] O_DIM  = 7'b0100001;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic       del;
    logic       nck;
    logic       dim;
    logic       dd;
    logic       md;
    logic       fc;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  vend_dispense_sequencer #(
    .PULSE_CYCLES  (4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_deliver   (req_deliver),
    .req_nickel    (req_nickel),
    .req_dime      (req_dime),
    .req_doubledime(req_doubledime),
    .req_ready     (req_ready),
    .mech_done     (mech_done),
    .fault_clr     (fault_clr),
    .motor_on      (motor_on),
    .eject_nickel  (eject_nickel),
    .eject_dime    (eject_dime),
    .busy          (busy),
    .done          (done),
    .fault         (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] outs();
    return {req_ready, busy, done, fault, motor_on, eject_nickel, eject_dime};
  endfunction

  function automatic vec_t mk(input logic rst, valid, del, nck, dim, dd, md, fc,
                              input logic [6:0] exp);
    vec_t v;
    v = {rst, valid, del, nck, dim, dd, md, fc, exp};
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, d, n, dm, dd, md, fc);
    req_valid      = v;
    req_deliver    = d;
    req_nickel     = n;
    req_dime       = dm;
    req_doubledime = dd;
    mech_done      = md;
    fault_clr      = fc;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset held with a pending request, then accept deliver+nickel with mech_done tied high.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, O_IDLE));
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1, 0, O_SEL));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, O_MOT));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, O_MOT));  // request while busy is ignored
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, O_MOT));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, O_MOT));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, O_SEL));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, O_NCK));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, O_SEL));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, O_DONE));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_IDLE));

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      drive(vecs[i].valid, vecs[i].del, vecs[i].nck, vecs[i].dim, vecs[i].dd,
            vecs[i].md, vecs[i].fc);
      step();
      check($sformatf("vec%0d", i), {1'b0, outs()}, {1'b0, vecs[i].exp});
    end

    // Double dime: two 6-cycle bursts separated by one SEL cycle.
    drive(1, 0, 0, 0, 1, 0, 0);
    step();
    check("t3_accept", {1'b0, outs()}, {1'b0, O_SEL});
    check("t3_dimes2", {6'd0, dut.dimes_left}, 8'd2);
    for (int b = 0; b < 2; b++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
        step();
        check($sformatf("t3_burst%0d_c%0d", b, k), {1'b0, outs()}, {1'b0, O_DIM});
      end
      drive(0, 0, 0, 0, 0, 1, 0);
      step();
      check($sformatf("t3_gap%0d", b), {1'b0, outs()}, {1'b0, O_SEL});
      check($sformatf("t3_dimes_b%0d", b), {6'd0, dut.dimes_left}, 8'(1 - b));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("t3_done", {1'b0, outs()}, {1'b0, O_DONE});
    step();
    check("t3_idle", {1'b0, outs()}, {1'b0, O_IDLE});

    // Deliver with no mech_done: 20 motor cycles then FAULT until fault_clr.
    drive(1, 1, 0, 0, 0, 0, 0);
    step();
    check("t4_accept", {1'b0, outs()}, {1'b0, O_SEL});
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("t4_motor%0d", i), {1'b0, outs()}, {1'b0, O_MOT});
    end
    step();
    check("t4_fault", {1'b0, outs()}, {1'b0, O_FLT});
    drive(1, 1, 0, 1, 0, 0, 0);
    step();
    check("t4_fault_hold_req", {1'b0, outs()}, {1'b0, O_FLT});
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("t4_fault_hold", {1'b0, outs()}, {1'b0, O_FLT});
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    check("t4_clr_idle", {1'b0, outs()}, {1'b0, O_IDLE});
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("t4_no_done", {1'b0, outs()}, {1'b0, O_IDLE});

    // Early mech_done pulse ignored; completion on the 7th motor cycle honoured.
    drive(1, 1, 0, 0, 0, 0, 0);
    step();
    check("t5_accept", {1'b0, outs()}, {1'b0, O_SEL});
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("t5_c1", {1'b0, outs()}, {1'b0, O_MOT});
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    check("t5_c2_stale_done", {1'b0, outs()}, {1'b0, O_MOT});
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 3; i <= 7; i++) begin
      step();
      check($sformatf("t5_c%0d", i), {1'b0, outs()}, {1'b0, O_MOT});
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    check("t5_exit", {1'b0, outs()}, {1'b0, O_SEL});
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("t5_done", {1'b0, outs()}, {1'b0, O_DONE});

    // Reset in the middle of CHG_N, then an empty request.
    drive(1, 0, 1, 0, 0, 0, 0);
    step();
    check("t6_accept", {1'b0, outs()}, {1'b0, O_SEL});
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("t6_nck1", {1'b0, outs()}, {1'b0, O_NCK});
    step();
    check("t6_nck2", {1'b0, outs()}, {1'b0, O_NCK});
    reset = 1'b0;
    step();
    check("t6_reset_idle", {1'b0, outs()}, {1'b0, O_IDLE});
    reset = 1'b1;
    step();
    check("t6_job_lost", {1'b0, outs()}, {1'b0, O_IDLE});
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    check("t6_empty_sel", {1'b0, outs()}, {1'b0, O_SEL});
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("t6_empty_done", {1'b0, outs()}, {1'b0, O_DONE});
    step();
    check("t6_empty_idle", {1'b0, outs()}, {1'b0, O_IDLE});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
